bdi_line_compressor: RTL

Write-side Base-Delta-Immediate (BDI) compressor for the compressed L1 data array. It accepts a 16-word (512-bit) cacheline one word per beat and classifies it as zeros, repeated, base4-delta1 or uncompressed. It then emits the compressed 256-bit data field with its `compressed_mode` and `base_one_hot` metadata, in exactly the format the cache read-path decompressor consumes. It sits between the line-fill/refill path and the cache write channel.

---
 rtl/bdi_line_compressor.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/bdi_line_compressor.sv
// Write-side BDI compressor: collects a 16-word line, classifies it as zeros /
// repeated / base4-delta1 / uncompressed and emits the decompressor-ready field.
module bdi_line_compressor #(
  parameter int unsigned DATA_FIELD = 256,
  parameter int unsigned WORD_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WORD_WIDTH-1:0] in_word,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_FIELD-1:0] out_data,
  output logic [7:0]            out_compressed_mode,
  output logic [31:0]           out_base_one_hot,
  output logic                  out_half,
  output logic                  out_last
);

  localparam int unsigned NW = 16;
  localparam int unsigned CW = 4;
  localparam int unsigned DW = 8;
  localparam int unsigned BW = 32;
  localparam logic [CW-1:0] LAST_IDX = CW'(NW - 1);

  localparam logic [7:0] MODE_ZERO = 8'h01;
  localparam logic [7:0] MODE_REP  = 8'h02;
  localparam logic [7:0] MODE_B4D1 = 8'h04;
  localparam logic [7:0] MODE_UNC  = 8'h80;

  typedef enum logic [1:0] {
    S_COLLECT = 2'd0,
    S_EMIT    = 2'd1,
    S_EMIT_HI = 2'd2
  } state_e;

  state_e                        state_q, state_d;
  logic [CW-1:0]                 cnt_q, cnt_d;
  logic [NW-1:0][WORD_WIDTH-1:0] buf_q, buf_d;
  logic [NW-1:0][DW-1:0]         delta_q, delta_d;
  logic [WORD_WIDTH-1:0]         base_q, base_d;
  logic [NW-1:0]                 boh_q, boh_d;
  logic                          all_zero_q, all_zero_d;
  logic                          all_eq_q, all_eq_d;
  logic                          b4d1_ok_q, b4d1_ok_d;
  logic                          base_found_q, base_found_d;

  logic                          out_valid_q, out_valid_d;
  logic [DATA_FIELD-1:0]         out_data_q, out_data_d;
  logic [7:0]                    out_mode_q, out_mode_d;
  logic [BW-1:0]                 out_boh_q, out_boh_d;
  logic                          out_half_q, out_half_d;
  logic                          out_last_q, out_last_d;

  logic                          word_hs;
  logic                          word_imm;
  logic                          delta_fits;
  logic                          to_collect;
  logic [WORD_WIDTH-1:0]         diff;

  assign in_ready   = (state_q == S_COLLECT) && !rst;
  assign word_hs    = in_valid && in_ready;
  assign word_imm   = (in_word == {{(WORD_WIDTH-DW){in_word[DW-1]}}, in_word[DW-1:0]});
  assign diff       = in_word - base_q;
  // Signed 8-bit fit: upper bits from the sign bit down are all equal
  assign delta_fits = (&diff[WORD_WIDTH-1:DW-1]) || !(|diff[WORD_WIDTH-1:DW-1]);

  assign out_valid           = out_valid_q;
  assign out_data            = out_data_q;
  assign out_compressed_mode = out_mode_q;
  assign out_base_one_hot    = out_boh_q;
  assign out_half            = out_half_q;
  assign out_last            = out_last_q;

  // Next-state, running flags and registered output payload
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    buf_d        = buf_q;
    delta_d      = delta_q;
    base_d       = base_q;
    boh_d        = boh_q;
    all_zero_d   = all_zero_q;
    all_eq_d     = all_eq_q;
    b4d1_ok_d    = b4d1_ok_q;
    base_found_d = base_found_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_mode_d   = out_mode_q;
    out_boh_d    = out_boh_q;
    out_half_d   = out_half_q;
    out_last_d   = out_last_q;
    to_collect   = 1'b0;

    case (state_q)
      S_COLLECT: begin
        if (word_hs) begin
          buf_d[cnt_q] = in_word;
          cnt_d        = CW'(cnt_q + CW'(1));
          all_zero_d   = all_zero_q && (in_word == '0);
          all_eq_d     = all_eq_q && ((cnt_q == '0) || (in_word == buf_q[0]));
          if (word_imm) begin
            boh_d[cnt_q]   = 1'b0;
            delta_d[cnt_q] = in_word[DW-1:0];
          end else if (!base_found_q) begin
            base_d         = in_word;
            base_found_d   = 1'b1;
            boh_d[cnt_q]   = 1'b1;
            delta_d[cnt_q] = '0;
          end else begin
            b4d1_ok_d      = b4d1_ok_q && delta_fits;
            boh_d[cnt_q]   = 1'b1;
            delta_d[cnt_q] = diff[DW-1:0];
          end

          if (cnt_q == LAST_IDX) begin
            state_d     = S_EMIT;
            out_valid_d = 1'b1;
            out_half_d  = 1'b0;
            out_boh_d   = '0;
            if (all_zero_d) begin
              out_mode_d = MODE_ZERO;
              out_data_d = '0;
              out_last_d = 1'b1;
            end else if (all_eq_d) begin
              out_mode_d = MODE_REP;
              out_data_d = DATA_FIELD'(buf_d[0]);
              out_last_d = 1'b1;
            end else if (b4d1_ok_d) begin
              out_mode_d = MODE_B4D1;
              out_data_d = DATA_FIELD'({delta_d, base_d});
              out_boh_d  = BW'(boh_d);
              out_last_d = 1'b1;
            end else begin
              out_mode_d = MODE_UNC;
              out_data_d = DATA_FIELD'(buf_d[NW/2-1:0]);
              out_last_d = 1'b0;
            end
          end
        end
      end
      S_EMIT: begin
        if (out_ready) begin
          if (out_mode_q == MODE_UNC) begin
            state_d    = S_EMIT_HI;
            out_data_d = DATA_FIELD'(buf_q[NW-1:NW/2]);
            out_half_d = 1'b1;
            out_last_d = 1'b1;
          end else begin
            to_collect = 1'b1;
          end
        end
      end
      S_EMIT_HI: begin
        if (out_ready) begin
          to_collect = 1'b1;
        end
      end
      default: begin
        to_collect = 1'b1;
      end
    endcase

    // Returning to COLLECT clears the output beat and re-arms the line flags
    if (to_collect) begin
      state_d      = S_COLLECT;
      out_valid_d  = 1'b0;
      out_data_d   = '0;
      out_mode_d   = '0;
      out_boh_d    = '0;
      out_half_d   = 1'b0;
      out_last_d   = 1'b0;
      all_zero_d   = 1'b1;
      all_eq_d     = 1'b1;
      b4d1_ok_d    = 1'b1;
      base_found_d = 1'b0;
      base_d       = '0;
      boh_d        = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_COLLECT;
      cnt_q        <= '0;
      base_q       <= '0;
      boh_q        <= '0;
      all_zero_q   <= 1'b1;
      all_eq_q     <= 1'b1;
      b4d1_ok_q    <= 1'b1;
      base_found_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_mode_q   <= '0;
      out_boh_q    <= '0;
      out_half_q   <= 1'b0;
      out_last_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      base_q       <= base_d;
      boh_q        <= boh_d;
      all_zero_q   <= all_zero_d;
      all_eq_q     <= all_eq_d;
      b4d1_ok_q    <= b4d1_ok_d;
      base_found_q <= base_found_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_mode_q   <= out_mode_d;
      out_boh_q    <= out_boh_d;
      out_half_q   <= out_half_d;
      out_last_q   <= out_last_d;
    end
  end

  // Line buffer and per-word deltas are pure datapath; validity comes from cnt/state
  always_ff @(posedge clk) begin
    buf_q   <= buf_d;
    delta_q <= delta_d;
  end

endmodule
